ntt_addr_gen: RTL

Control/address generator that sits directly upstream of the two data_bank instances holding an N-point polynomial for the radix-2 NTT datapath.
- Issues one butterfly per cycle in Cooley-Tukey order.
- Produces read addresses and read enable for both banks, plus twiddle index and stage number for the butterfly unit.
- Produces write addresses and write enable, delayed by the butterfly pipeline latency.
- Bank mapping is conflict-free: index i lives in bank parity(i) (XOR of all index bits), at bank address i>>1. Both data_bank instances use addr_width=LOGN-1 and depth=N/2.

---
 rtl/ntt_ag_pkg.sv | 23 ++
 rtl/ntt_addr_delay.sv | 25 ++
 rtl/ntt_addr_gen.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/ntt_ag_pkg.sv
// rtl/ntt_ag_pkg.sv - shared constants, FSM state type and index helpers for the NTT address generator
package ntt_ag_pkg;

  localparam int LOGN_DEF    = 9;
  localparam int N_DEF       = 1 << LOGN_DEF;
  localparam int ADDR_W_DEF  = LOGN_DEF - 1;
  localparam int LATENCY_DEF = 4;
  localparam int IDX_W       = 16;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} ag_state_e;

  function automatic logic parity(input logic [IDX_W-1:0] v);
    return ^v;
  endfunction

  // Open a zero at bit pos: bits below pos stay, bits at/above pos move up by one.
  function automatic logic [IDX_W-1:0] insert_zero(input logic [IDX_W-1:0] v, input logic [3:0] pos);
    logic [IDX_W-1:0] lo_mask;
    lo_mask = (IDX_W'(1) << pos) - IDX_W'(1);
    return ((v & ~lo_mask) << 1) | (v & lo_mask);
  endfunction

endpackage

// File: rtl/ntt_addr_delay.sv
// rtl/ntt_addr_delay.sv - reset-cleared LATENCY-deep shift register carrying read fields to the write side
module ntt_addr_delay #(
  parameter int W       = 1,
  parameter int LATENCY = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] pipe_q [LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[LATENCY-1];

endmodule

// File: rtl/ntt_addr_gen.sv
// rtl/ntt_addr_gen.sv - radix-2 NTT butterfly address/control generator for two parity-mapped banks
// Optional NTT_AG_INV_EN adds the inv input selecting Gentleman-Sande order.
module ntt_addr_gen
  import ntt_ag_pkg::*;
#(
  parameter int LOGN    = LOGN_DEF,
  parameter int LATENCY = LATENCY_DEF,
  parameter int ADDR_W  = LOGN - 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
`ifdef NTT_AG_INV_EN
  input  logic              inv,
`endif
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr0,
  output logic [ADDR_W-1:0] rd_addr1,
  output logic              rd_swap,
  output logic [LOGN-1:0]   tw_idx,
  output logic [3:0]        stage,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr0,
  output logic [ADDR_W-1:0] wr_addr1,
  output logic              wr_swap
);

  localparam int KW = LOGN - 1;
  localparam int DW = 2 * ADDR_W + 2;
  localparam logic [KW-1:0] K_LAST = KW'((1 << KW) - 1);
  localparam logic [4:0]    D_LAST = 5'(LATENCY - 1);
  localparam logic [3:0]    S_LAST = 4'(LOGN - 1);

  ag_state_e         state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [3:0]        s_q, s_d;
  logic [4:0]        dcnt_q, dcnt_d;
  logic              inv_q, inv_d;

  logic              busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d, rd_swap_q, rd_swap_d;
  logic [ADDR_W-1:0] rd_addr0_q, rd_addr0_d, rd_addr1_q, rd_addr1_d;
  logic [LOGN-1:0]   tw_q, tw_d;
  logic [3:0]        stage_q, stage_d;

  logic [3:0]        p;
  logic [LOGN-1:0]   j_idx;
  logic [ADDR_W-1:0] j_addr, partner_addr;
  logic              swap;
  logic [DW-1:0]     wr_bus;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      k_q        <= '0;
      s_q        <= '0;
      dcnt_q     <= '0;
      inv_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_swap_q  <= 1'b0;
      rd_addr0_q <= '0;
      rd_addr1_q <= '0;
      tw_q       <= '0;
      stage_q    <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      s_q        <= s_d;
      dcnt_q     <= dcnt_d;
      inv_q      <= inv_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      rd_swap_q  <= rd_swap_d;
      rd_addr0_q <= rd_addr0_d;
      rd_addr1_q <= rd_addr1_d;
      tw_q       <= tw_d;
      stage_q    <= stage_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    s_d     = s_q;
    dcnt_d  = dcnt_q;
    inv_d   = inv_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        k_d     = '0;
        s_d     = '0;
`ifdef NTT_AG_INV_EN
        inv_d   = inv;
`else
        inv_d   = 1'b0;
`endif
      end
      RUN: begin
        k_d = k_q + 1'b1;
        if (k_q == K_LAST) begin
          state_d = DRAIN;
          k_d     = '0;
          dcnt_d  = '0;
        end
      end
      DRAIN: begin
        dcnt_d = dcnt_q + 5'd1;
        if (dcnt_q == D_LAST) begin
          if (s_q == S_LAST) state_d = DONE;
          else begin
            state_d = RUN;
            s_d     = s_q + 4'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        s_d     = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Forward: stride bit p walks down from the MSB; inverse: it walks up from bit 0.
  always_comb begin
    p            = inv_q ? s_q : S_LAST - s_q;
    j_idx        = LOGN'(insert_zero(IDX_W'(k_q), p));
    swap         = parity(IDX_W'(j_idx));
    j_addr       = ADDR_W'(j_idx >> 1);
    partner_addr = ADDR_W'((j_idx | (LOGN'(1) << p)) >> 1);

    rd_en_d    = (state_q == RUN);
    rd_swap_d  = 1'b0;
    rd_addr0_d = '0;
    rd_addr1_d = '0;
    tw_d       = '0;
    if (state_q == RUN) begin
      rd_swap_d  = swap;
      rd_addr0_d = swap ? partner_addr : j_addr;
      rd_addr1_d = swap ? j_addr : partner_addr;
      tw_d       = inv_q ? LOGN'((IDX_W'(1) << (S_LAST - s_q)) + (IDX_W'(k_q) >> s_q))
                         : LOGN'((IDX_W'(1) << s_q) + (IDX_W'(k_q) >> p));
    end
    stage_d = s_q;
    busy_d  = (state_q == RUN) || (state_q == DRAIN);
    done_d  = (state_q == DONE);
  end

  ntt_addr_delay #(.W(DW), .LATENCY(LATENCY)) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   ({rd_en_q, rd_addr0_q, rd_addr1_q, rd_swap_q}),
    .q_o   (wr_bus)
  );

  assign {wr_en, wr_addr0, wr_addr1, wr_swap} = wr_bus;

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_en    = rd_en_q;
  assign rd_addr0 = rd_addr0_q;
  assign rd_addr1 = rd_addr1_q;
  assign rd_swap  = rd_swap_q;
  assign tw_idx   = tw_q;
  assign stage    = stage_q;

endmodule
